// File: rtl/mem_wb_sram_stage_if.sv
// Half-word SRAM pin bundle between the MEM/WB stage (master) and the external SRAM (slave).
interface mem_wb_sram_stage_if #(
  parameter int SRAM_ADDR_LEN = 18
);
  logic [SRAM_ADDR_LEN-1:0] sram_addr;
  logic [15:0]              sram_wdata;
  logic [15:0]              sram_rdata;
  logic                     sram_we_n;
  logic                     sram_oe_n;

  modport master (
    output sram_addr, sram_wdata, sram_we_n, sram_oe_n,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr, sram_wdata, sram_we_n, sram_oe_n,
    output sram_rdata
  );
endinterface

// File: rtl/mem_wb_sram_stage.sv
// ARM memory-access stage plus MEM/WB register; each 32-bit LDR/STR becomes two
// half-word SRAM accesses of SRAM_WAIT cycles each, with upstream frozen meanwhile.
module mem_wb_sram_stage #(
  parameter int DATA_LEN      = 32,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int SRAM_WAIT     = 4,
  parameter int BASE_ADDR     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  input  logic                wb_en_in,
  input  logic [3:0]          dest_in,
  input  logic [DATA_LEN-1:0] alu_res,
  input  logic [DATA_LEN-1:0] st_val,
  output logic                freeze,
  output logic                wb_en,
  output logic [3:0]          dest_wb,
  output logic [DATA_LEN-1:0] result_wb,
  mem_wb_sram_stage_if.master sram
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t                   state, state_nx;
  logic [3:0]               cnt;
  logic                     op_store;
  logic [15:0]              lo_q, hi_q;
  logic                     req;
  logic                     last;
  logic [SRAM_ADDR_LEN-2:0] word;
  logic [SRAM_ADDR_LEN-1:0] lo_addr, hi_addr;

  assign req     = mem_r_en | mem_w_en;
  assign last    = (cnt == 4'(SRAM_WAIT - 1));
  // Offset below BASE_ADDR wraps silently into the top of the SRAM.
  assign word    = (SRAM_ADDR_LEN-1)'((alu_res - DATA_LEN'(BASE_ADDR)) >> 2);
  assign lo_addr = {word, 1'b0};
  assign hi_addr = {word, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req)  state_nx = LO;
      LO:      if (last) state_nx = HI;
      HI:      if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    freeze = 1'b0;
    case (state)
      IDLE:    freeze = req;
      LO, HI:  freeze = 1'b1;
      default: freeze = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en           <= 1'b0;
      dest_wb         <= '0;
      result_wb       <= '0;
      cnt             <= '0;
      op_store        <= 1'b0;
      lo_q            <= '0;
      hi_q            <= '0;
      sram.sram_addr  <= '0;
      sram.sram_wdata <= '0;
      sram.sram_we_n  <= 1'b1;
      sram.sram_oe_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!req) begin
            wb_en     <= wb_en_in;
            dest_wb   <= dest_in;
            result_wb <= alu_res;
          end else begin
            wb_en          <= 1'b0;
            cnt            <= '0;
            op_store       <= mem_w_en;
            sram.sram_addr <= lo_addr;
            if (mem_w_en) begin
              sram.sram_wdata <= st_val[15:0];
              sram.sram_we_n  <= 1'b0;
            end else begin
              sram.sram_oe_n  <= 1'b0;
            end
          end
        end
        LO: begin
          if (last) begin
            cnt            <= '0;
            sram.sram_addr <= hi_addr;
            if (op_store) sram.sram_wdata <= st_val[31:16];
            else          lo_q            <= sram.sram_rdata;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HI: begin
          if (last) begin
            cnt            <= '0;
            sram.sram_we_n <= 1'b1;
            sram.sram_oe_n <= 1'b1;
            if (!op_store) hi_q <= sram.sram_rdata;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (op_store) begin
            wb_en <= 1'b0;
          end else begin
            wb_en     <= wb_en_in;
            dest_wb   <= dest_in;
            result_wb <= DATA_LEN'({hi_q, lo_q});
          end
        end
        default: wb_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/mem_wb_sram_stage.md
Name: mem_wb_sram_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the ARM pipeline. It feeds the register file write-back port directly (wb_en, dest_wb, result_wb).
- Executes LDR/STR against an external 16-bit SRAM as two half-word accesses per 32-bit word.
- Stalls the upstream pipeline through freeze while an access is in progress.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- DATA_LEN, 32, width of ALU result, store value and write-back data.
- SRAM_ADDR_LEN, 18, SRAM half-word address width.
- SRAM_WAIT, 4, cycles each half-word access is held on the SRAM pins (legal range 1..15).
- BASE_ADDR, 1024, byte address that maps to SRAM word 0.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- mem_r_en  input  1  load request from EX/MEM.
- mem_w_en  input  1  store request from EX/MEM.
- wb_en_in  input  1  instruction writes a register.
- dest_in  input  4  destination register index.
- alu_res  input  DATA_LEN  ALU result, or byte address for memory ops.
- st_val  input  DATA_LEN  store data.
- freeze  output  1  stall request to all upstream stages (combinational).
- wb_en  output  1  register-file write enable (registered).
- dest_wb  output  4  register-file write index (registered).
- result_wb  output  DATA_LEN  register-file write data (registered).
- sram_addr  output  SRAM_ADDR_LEN  SRAM half-word address (registered).
- sram_wdata  output  16  SRAM write data (registered).
- sram_rdata  input  16  SRAM read data, valid while sram_oe_n=0.
- sram_we_n  output  1  SRAM write strobe, active low (registered).
- sram_oe_n  output  1  SRAM output enable, active low (registered).

Behaviour:
- Reset: on a clk edge with rst=1, all registered outputs clear: wb_en=0, dest_wb=0, result_wb=0, sram_addr=0, sram_wdata=0. Strobes go inactive: sram_we_n=1, sram_oe_n=1. FSM goes to IDLE and the wait counter clears, so freeze=0. This applies mid-access too: the access is abandoned, nothing is written back, and the next cycle starts from IDLE.
- Request and priority: req = mem_r_en | mem_w_en. If mem_r_en and mem_w_en are both 1, the instruction is treated as a store.
- Address mapping: word = (alu_res - BASE_ADDR) >> 2, truncated to SRAM_ADDR_LEN-1 bits; the result wraps with no error. Low half-word is at {word,0}, high half-word at {word,1}.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE, req=0: wb registers capture {wb_en_in, dest_in, alu_res}; freeze=0.
  - IDLE, req=1: freeze=1; wb_en register captures 0 (bubble); go to LO with the counter cleared. Drive sram_addr=low address.
    - Store: sram_wdata=st_val[15:0], sram_we_n=0.
    - Load: sram_oe_n=0.
  - LO: lasts SRAM_WAIT cycles; freeze=1 and wb_en=0 throughout. On the last cycle:
    - Load: latch sram_rdata as the low half.
    - Drive sram_addr=high address; for a store also drive sram_wdata=st_val[31:16].
    - Go to HI.
  - HI: lasts SRAM_WAIT cycles, same rules. On the last cycle a load latches the high half. Strobes return to 1; go to DONE.
  - DONE: exactly one cycle; freeze=0, so upstream advances at the end of this cycle.
    - Load: wb registers capture {wb_en_in, dest_in, {hi,lo}}.
    - Store: wb registers capture wb_en=0.
    - Always go to IDLE. The still-present request is not re-triggered.
- Latency, request first seen at cycle 0:
  - freeze is high for cycles 0..2*SRAM_WAIT.
  - DONE occurs at cycle 2*SRAM_WAIT+1.
  - Load data appears on result_wb/wb_en at cycle 2*SRAM_WAIT+2.
  - A non-memory instruction appears at cycle 1.
- Ignored inputs: wb_en_in is ignored for stores. alu_res and st_val are sampled continuously while frozen; upstream holds them stable.
- Back-to-back memory instructions: each one takes the full 2*SRAM_WAIT+2 sequence starting from IDLE.
- Write-back hazard: wb_en is high for exactly one cycle per completed writing instruction, never during freeze.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then ADD with wb_en_in=1, dest_in=3, alu_res=25 → freeze=0; at cycle 1 wb_en=1, dest_wb=3, result_wb=25.
- Store then load, SRAM_WAIT=4, SRAM model attached:
  - STR alu_res=1028, st_val=0xDEADBEEF → freeze high cycles 0..8; sram_addr=2 with wdata 0xBEEF, then sram_addr=3 with wdata 0xDEAD; wb_en stays 0.
  - Following LDR dest_in=6, alu_res=1028 → result_wb=0xDEADBEEF, wb_en=1 at cycle 10.
- Back-to-back loads of addresses 1024 and 1032 → two freeze windows of 9 cycles separated by one DONE cycle with freeze=0; two distinct one-cycle wb_en pulses.
- Both mem_r_en and mem_w_en high with alu_res=1024, st_val=7 → store performed; SRAM half-words 0/1 hold 7/0; no write-back.
- Reset asserted during HI of a load → next cycle freeze=0, sram_oe_n=1, wb_en=0, state IDLE; a subsequent ADD passes with 1-cycle latency.
- Address wrap: alu_res=1020 → word wraps to 0x1FFFF, sram_addr=0x3FFFE then 0x3FFFF; no hang, with the normal 2*SRAM_WAIT+2 timing.
